uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer placed directly downstream of uart_rx. Captures each completed received word on a one-cycle wr_valid strobe.
//  Holds up to DEPTH words until the consumer (CPU/command logic) pops them.
//  First-word-fall-through: the head word is presented on rd_data whenever not empty.
//  Flags full, almost-full and a sticky overflow so dropped bytes are never silent.
// PARAMETERS
//  DATA_BITS   8    width of one received word; must match uart_rx DATA_BITS
//  DEPTH       16   number of entries; power of 2, >= 2
//  AFULL_LVL   12   almost_full asserts when count >= AFULL_LVL (1..DEPTH)
//  ADDR_W      $clog2(DEPTH)  derived; not overridden
// PORTS
//  sys_clk       in   1            system clock; sole clock, all logic on rising edge
//  rst           in   1            synchronous reset, active-high
//  wr_data       in   DATA_BITS    received word from uart_rx
//  wr_valid      in   1            1-cycle strobe: wr_data holds a new complete word
//  rd_en         in   1            pop head entry (ignored when empty)
//  ovf_clr       in   1            clear sticky overflow flag
//  rd_data       out  DATA_BITS    head entry; 0 when empty
//  empty         out  1            no entries stored
//  full          out  1            count == DEPTH
//  almost_full   out  1            count >= AFULL_LVL
//  count         out  ADDR_W+1     entries stored, 0..DEPTH
//  overflow      out  1            sticky: a write was dropped
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, rd_data=0.
//    Memory contents are not cleared. Reset overrides every other input in that cycle.
//  - Pointers are ADDR_W+1 bits. The MSB is a wrap bit; both pointers wrap naturally modulo 2*DEPTH.
//    empty = (wr_ptr == rd_ptr); full = (MSBs differ && low ADDR_W bits equal).
//  - count = wr_ptr - rd_ptr, taken modulo 2^(ADDR_W+1). All flags are derived combinationally from registered pointers.
//  - Write accepted = wr_valid && (!full || rd_en). On accept: mem[wr_ptr[ADDR_W-1:0]] <= wr_data; wr_ptr++.
//  - Pop accepted = rd_en && !empty. On accept: rd_ptr++.
//  - Latency: a word written at edge N is visible on rd_data with empty=0 after edge N (FWFT, 1 cycle).
//    A write into an empty FIFO cannot be popped in the same cycle; rd_en is ignored because empty=1.
//  - Simultaneous write and pop when not empty: both occur, count unchanged.
//    When full with rd_en=1: the pop frees a slot, so the write is accepted and no overflow occurs.
//  - wr_valid while full with rd_en=0: the word is dropped, pointers are unchanged, and overflow <= 1.
//  - overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr=1 clears it.
//  - rd_en while empty: no effect; there is no underflow flag.
//  - rd_data = mem[rd_ptr[ADDR_W-1:0]] when !empty, else all-zero. This is an asynchronous read of the register array.
//  - Upstream contract: wr_valid is high for exactly one sys_clk cycle per received word. Back-to-back strobes are legal.
// STRUCTURE
//  - Shared header uart_defs.vh: default DATA_BITS; a FIFO default-depth constant.
//    Both are shared with uart_rx and top.
//  - Sub-module uart_rx_fifo_mem: DEPTH x DATA_BITS register array with 1 synchronous write port and 1 async read port.
//    It has no reset on storage.
//  - uart_rx_fifo holds the pointers, the flag logic, the overflow register and the rd_data gating.
// TESTING
//  1. Reset: drive rst=1 for 2 cycles with wr_valid=1 -> empty=1, count=0, overflow=0, rd_data=0.
//  2. Fill/drain: write 0x01..0x10 (16 strobes) -> full=1, count=16, almost_full asserted from count=12.
//     Then pop 16 times -> 0x01..0x10 in order, empty=1.
//  3. Overflow: at full, strobe 0xAA with rd_en=0 -> count stays 16, overflow=1, the head is still 0x01.
//     Then ovf_clr together with another dropped write -> overflow stays 1. ovf_clr alone -> overflow=0.
//  4. Full + simultaneous: at full, wr_valid=1 (0x55) and rd_en=1 -> count=16, no overflow.
//     The last entry read out is 0x55.
//  5. Wrap: 40 write/pop pairs, count held at 3 -> data order preserved across pointer wrap, no spurious full/empty.
//  6. Empty corner: rd_en on empty -> no change. Write 0x3C -> rd_data=0x3C one edge later.
//     Assert rst mid-stream at count=5 -> count=0, empty=1.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults for the UART receive path: word width, FIFO depth and
// almost-full threshold, imported by uart_rx_fifo and its storage array.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_AFULL_LVL = 12;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_BITS register array: one synchronous write port, one
// asynchronous read port, storage deliberately left unreset.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = FIFO_DEPTH,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind uart_rx: wrap-bit pointers,
// combinational flags, sticky overflow and zero-gated head output.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AFULL_LVL = FIFO_AFULL_LVL,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  input  logic                 rd_en,
  input  logic                 ovf_clr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_W:0]      count,
  output logic                 overflow
);

  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_LVL);

  logic [ADDR_W:0]      wr_ptr_r;
  logic [ADDR_W:0]      rd_ptr_r;
  logic                 overflow_r;
  logic                 empty_s;
  logic                 full_s;
  logic                 almost_full_s;
  logic [ADDR_W:0]      count_s;
  logic                 wr_accept_s;
  logic                 rd_accept_s;
  logic                 wr_drop_s;
  logic [DATA_BITS-1:0] mem_rd_data_s;
  logic [DATA_BITS-1:0] rd_data_s;

  uart_rx_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (sys_clk),
    .we    (wr_accept_s),
    .waddr (wr_ptr_r[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_r[ADDR_W-1:0]),
    .rdata (mem_rd_data_s)
  );

  // Flags, accept decisions and head gating, all from registered pointers
  always_comb begin
    empty_s       = (wr_ptr_r == rd_ptr_r);
    full_s        = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                    (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
    count_s       = wr_ptr_r - rd_ptr_r;
    almost_full_s = (count_s >= AFULL_CNT);
    // A pop at full frees the slot the incoming word lands in; reset blocks both.
    rd_accept_s   = rd_en && !empty_s && !rst;
    wr_accept_s   = wr_valid && (!full_s || rd_en) && !rst;
    wr_drop_s     = wr_valid && full_s && !rd_en && !rst;
    if (empty_s) begin
      rd_data_s = {DATA_BITS{1'b0}};
    end else begin
      rd_data_s = mem_rd_data_s;
    end
  end

  // Write and read pointers, wrapping naturally modulo 2*DEPTH
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_r <= {(ADDR_W + 1){1'b0}};
      rd_ptr_r <= {(ADDR_W + 1){1'b0}};
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_accept_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (wr_drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end
  end

  assign rd_data     = rd_data_s;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = almost_full_s;
  assign count       = count_s;
  assign overflow    = overflow_r;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model compared every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = 8'h00;
  logic          wr_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [4:0]    count;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mq [$];
  bit            m_ovf = 1'b0;
  bit            m_valid = 1'b0;

  uart_rx_fifo #(
    .DATA_BITS (DW),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .rd_en       (rd_en),
    .ovf_clr     (ovf_clr),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words and a sticky drop flag
  always @(posedge sys_clk) begin
    int sz;
    bit pop, wacc, wdrop;
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else begin
      sz    = mq.size();
      pop   = rd_en && (sz > 0);
      wacc  = wr_valid && ((sz < DEPTH) || rd_en);
      wdrop = wr_valid && !wacc;
      if (pop) void'(mq.pop_front());
      if (wacc) mq.push_back(wr_data);
      if (wdrop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("count",       {27'd0, count},       mq.size());
      check("empty",       {31'd0, empty},       {31'd0, mq.size() == 0});
      check("full",        {31'd0, full},        {31'd0, mq.size() == DEPTH});
      check("almost_full", {31'd0, almost_full}, {31'd0, mq.size() >= AFULL});
      check("overflow",    {31'd0, overflow},    {31'd0, m_ovf});
      check("rd_data",     {24'd0, rd_data},     (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0);
    end
  end

  // One clock of stimulus: inputs set after an edge, held through the next
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic re,
                      input logic oc, input logic r);
    wr_valid = wv;
    wr_data  = wd;
    rd_en    = re;
    ovf_clr  = oc;
    rst      = r;
    @(posedge sys_clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] wd);
    step(1'b1, wd, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string name, input logic [DW-1:0] exp);
    check(name, {24'd0, rd_data}, {24'd0, exp});
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge sys_clk);
    #2;
    // Reset with a write strobe present
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_ovf",   {31'd0, overflow}, 32'd0);
    check("rst_rdata", {24'd0, rd_data}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      if (i == 11) check("afull_at_11", {31'd0, almost_full}, 32'd0);
      if (i == 12) check("afull_at_12", {31'd0, almost_full}, 32'd1);
    end
    check("fill_full",  {31'd0, full}, 32'd1);
    check("fill_count", {27'd0, count}, 32'd16);

    // Overflow at full
    push(8'hAA);
    check("ovf_count", {27'd0, count}, 32'd16);
    check("ovf_set",   {31'd0, overflow}, 32'd1);
    check("ovf_head",  {24'd0, rd_data}, 32'h01);
    step(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0);
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // Drain in order
    for (int i = 1; i <= 16; i++) pop_expect("drain1", 8'(i));
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Full plus simultaneous write/pop
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("fullsim_count", {27'd0, count}, 32'd16);
    check("fullsim_ovf",   {31'd0, overflow}, 32'd0);
    for (int i = 1; i < 16; i++) pop_expect("drain2", 8'h20 + 8'(i));
    pop_expect("last_is_55", 8'h55);

    // Wrap: hold three entries across 40 write/pop pairs
    for (int i = 0; i < 3; i++) push(8'h80 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      check("wrap_head", {24'd0, rd_data}, {24'd0, 8'h80 + 8'(i)});
      step(1'b1, 8'h83 + 8'(i), 1'b1, 1'b0, 1'b0);
      check("wrap_count", {27'd0, count}, 32'd3);
    end
    for (int i = 40; i < 43; i++) pop_expect("wrap_tail", 8'h80 + 8'(i));

    // Empty corners
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("empty_pop_count", {27'd0, count}, 32'd0);
    check("empty_pop_rdata", {24'd0, rd_data}, 32'd0);
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    check("fwft_rdata", {24'd0, rd_data}, 32'h3C);
    check("fwft_count", {27'd0, count}, 32'd1);
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    check("pre_rst_count", {27'd0, count}, 32'd5);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("mid_rst_count", {27'd0, count}, 32'd0);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
